flash_cmd_exec_sclk: RTL
========================

Name: flash_cmd_exec_sclk

Overview:
SCLK-domain command executor that sits directly downstream of the req/ack CDC slave. It consumes a synchronized command (cmd/addr/wdata/abort) qualified by a one-cycle valid pulse and sequences word accesses on a single-port flash-like array macro. It returns read data, a response/error bit and a one-cycle done pulse, which the handshake stage converts into ack_sclk.

Parameters:
ADDR_W, 10, array address width; the array holds 2**ADDR_W words.
DATA_W, 10, word width.
ROW_WORDS, 16, words per row; must be a power of 2 and no greater than 2**ADDR_W.
WR_CYCLES, 3, SCLK cycles per word program, strobe cycle included; at least 1.
READ_LAT, 2, array read latency in cycles after the strobe cycle; at least 1.

Ports:
SCLK  in  1  clock
RESETn_sclk  in  1  reset; asynchronous, active-low
cmd_valid_sclk  in  1  one-cycle command pulse (req_sample_pulse from the CDC slave)
cmd_sclk  in  3  0=IDLE, 1=READ, 2=WRITE, 3=ROW_WRITE, 4=ERASE, 5=MASS_ERASE
addr_sclk  in  ADDR_W  word address
wdata_sclk  in  DATA_W  write/fill data
abort_sclk  in  1  level; abort request for multi-word operations
busy_sclk  out  1  operation in progress
done_sclk  out  1  one-cycle completion pulse
resp_sclk  out  1  1 = error/aborted; valid while done_sclk is high and held until the next done
rdata_sclk  out  DATA_W  read result; held until the next READ completes
mem_cs_sclk  out  1  array strobe
mem_we_sclk  out  1  1 = program, 0 = read; meaningful only while mem_cs_sclk is high
mem_addr_sclk  out  ADDR_W  array address
mem_wdata_sclk  out  DATA_W  array program data
mem_rdata_sclk  in  DATA_W  array read data

Behaviour:
- Reset (async): all outputs go to 0 immediately and the FSM enters IDLE. A reset mid-operation drops mem_cs_sclk at once and no done pulse follows.
- All outputs are registered. Cycle 0 is the cycle in which cmd_valid_sclk is sampled high in IDLE; cmd, addr and wdata are latched in that cycle.
- cmd_valid_sclk outside IDLE is ignored and changes no state.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, PROG, PROG_WAIT, DONE.
- busy_sclk is high from cycle 1 through the DONE cycle inclusive. A new command can be accepted in the cycle after DONE.
- READ:
  - Cycle 1 (RD_ISSUE): mem_cs=1, we=0, mem_addr=addr.
  - RD_WAIT lasts READ_LAT cycles. mem_rdata is captured at the end of cycle 1+READ_LAT.
  - DONE is cycle 2+READ_LAT: done=1, resp=0, new rdata_sclk visible.
- Program operations cover N words:
  - WRITE: N=1 at addr, data = wdata.
  - ROW_WRITE: N=ROW_WORDS from the row base (addr with the low log2(ROW_WORDS) bits cleared), every word = wdata.
  - ERASE: same range as ROW_WRITE, data = all ones.
  - MASS_ERASE: N=2**ADDR_W from address 0, data = all ones.
  - Per word: one PROG cycle (cs=1, we=1), then WR_CYCLES-1 PROG_WAIT cycles (cs=0). The address increments by 1 per word; the word counter is ADDR_W+1 bits wide so MASS_ERASE terminates with no wrap. Any internal address wrap is modulo 2**ADDR_W.
  - DONE is cycle N*WR_CYCLES+1, with resp=0.
- Abort:
  - abort_sclk is sampled every cycle in PROG/PROG_WAIT. If seen high, the current word completes its full WR_CYCLES, no further words are issued, and DONE follows with resp=1.
  - abort on the final word still gives resp=1.
  - abort in IDLE or on READ is ignored.
- cmd codes 0, 6, 7 with cmd_valid: no array access, DONE in cycle 1 with resp=1.
- rdata_sclk is unchanged by non-READ commands.

Optional Feature:
FLASH_WRPROT_EN:
- Defined: adds input wp_sclk (1 bit), sampled in cycle 0. When high, WRITE, ROW_WRITE, ERASE and MASS_ERASE perform no array access and reach DONE in cycle 1 with resp=1. READ is unaffected.
- Undefined: no wp_sclk port; all programs execute as above.

Decomposition:
- Package flash_cmd_pkg:
  - cmd code localparams (IDLE..MASS_ERASE), matching the CDC stage encoding.
  - FSM state typedef.
  - erase fill constant (all ones).
- Sub-module flash_prog_timer: loadable down-counter producing a word-complete pulse after WR_CYCLES cycles. Instantiated once.

Test Plan:
- Reset, then READ addr=0x005 with array word 0x2A5 -> mem_cs one cycle at cycle 1; done at cycle 4 (READ_LAT=2); rdata=0x2A5, resp=0.
- WRITE addr=0x3FF, wdata=0x155 -> single strobe at 0x3FF with data 0x155; done at cycle 4; resp=0.
- ERASE addr=0x023 -> 16 strobes at 0x020..0x02F, data 0x3FF, spaced 3 cycles apart; done at cycle 49; resp=0.
- MASS_ERASE with abort_sclk raised during word 5 -> exactly 6 strobes (0x000..0x005); done after the sixth word's wait; resp=1.
- cmd=7, then cmd_valid pulsed again while a ROW_WRITE is busy -> first gives done at cycle 1 with resp=1; the second pulse is ignored and the ROW_WRITE completes normally.
- Async reset asserted mid-ROW_WRITE -> mem_cs, busy and done drop immediately; after release the FSM is IDLE and a READ works; with FLASH_WRPROT_EN and wp_sclk=1, WRITE gives no strobe and resp=1.

Source files
------------

// File: rtl/flash_cmd_pkg.sv
// Shared definitions for the SCLK-domain flash command executor:
// command codes, FSM states and the erase fill pattern.
package flash_cmd_pkg;

  localparam logic [2:0] CMD_IDLE       = 3'd0;
  localparam logic [2:0] CMD_READ       = 3'd1;
  localparam logic [2:0] CMD_WRITE      = 3'd2;
  localparam logic [2:0] CMD_ROW_WRITE  = 3'd3;
  localparam logic [2:0] CMD_ERASE      = 3'd4;
  localparam logic [2:0] CMD_MASS_ERASE = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_PROG,
    ST_PROG_WAIT,
    ST_DONE
  } state_t;

  // Erased words read back as all ones.
  localparam logic ERASE_FILL_BIT = 1'b1;

  function automatic logic is_prog_cmd(
    input logic [2:0] c
  );
    return (c == CMD_WRITE)     ||
           (c == CMD_ROW_WRITE) ||
           (c == CMD_ERASE)     ||
           (c == CMD_MASS_ERASE);
  endfunction

endpackage

// File: rtl/flash_cmd_exec_sclk_prog_timer.sv
// flash_prog_timer: loadable down-counter, word_done_sclk is high in
// the last of WR_CYCLES cycles following a load (SCLK, RESETn_sclk).
module flash_prog_timer #(
  parameter int WR_CYCLES = 3
) (
  input  logic SCLK,
  input  logic RESETn_sclk,
  input  logic load_sclk,
  output logic word_done_sclk
);

  localparam int CW = $clog2(WR_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          run;

  always_ff @(posedge SCLK or negedge RESETn_sclk) begin
    if (!RESETn_sclk) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load_sclk) begin
      cnt <= CW'(WR_CYCLES - 1);
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) begin
        run <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign word_done_sclk = run && (cnt == '0);

endmodule

// File: rtl/flash_cmd_exec_sclk.sv
// SCLK-domain command executor: sequences READ / program / erase word
// accesses on a single-port array and returns rdata, resp and a done
// pulse. Ports: SCLK, RESETn_sclk, cmd_valid/cmd/addr/wdata/abort in,
// busy/done/resp/rdata out, mem_cs/we/addr/wdata out, mem_rdata in.
// Optional FLASH_WRPROT_EN adds wp_sclk, which blocks all programs.
module flash_cmd_exec_sclk #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 10,
  parameter int ROW_WORDS = 16,
  parameter int WR_CYCLES = 3,
  parameter int READ_LAT  = 2
) (
  input  logic              SCLK,
  input  logic              RESETn_sclk,
  input  logic              cmd_valid_sclk,
  input  logic [2:0]        cmd_sclk,
  input  logic [ADDR_W-1:0] addr_sclk,
  input  logic [DATA_W-1:0] wdata_sclk,
  input  logic              abort_sclk,
`ifdef FLASH_WRPROT_EN
  input  logic              wp_sclk,
`endif
  output logic              busy_sclk,
  output logic              done_sclk,
  output logic              resp_sclk,
  output logic [DATA_W-1:0] rdata_sclk,
  output logic              mem_cs_sclk,
  output logic              mem_we_sclk,
  output logic [ADDR_W-1:0] mem_addr_sclk,
  output logic [DATA_W-1:0] mem_wdata_sclk,
  input  logic [DATA_W-1:0] mem_rdata_sclk
);

  import flash_cmd_pkg::*;

  localparam int RL_W = $clog2(READ_LAT + 1);
  localparam int WC_W = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] ROW_MASK =
    ~ADDR_W'(ROW_WORDS - 1);
  localparam logic [WC_W-1:0] N_ONE = WC_W'(1);
  localparam logic [WC_W-1:0] N_ROW = WC_W'(ROW_WORDS);
  localparam logic [WC_W-1:0] N_ALL =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [DATA_W-1:0] FILL =
    {DATA_W{ERASE_FILL_BIT}};

  state_t state, state_d;

  logic [WC_W-1:0]   wcnt, wcnt_d;
  logic [RL_W-1:0]   rdcnt, rdcnt_d;
  logic              abort_seen, abort_d;
  logic              busy_d, done_d, resp_d;
  logic              cs_d, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, rdata_d;
  logic              load, word_done;
  logic              wp, abort_now;
  logic              is_rd, is_pg;

`ifdef FLASH_WRPROT_EN
  assign wp = wp_sclk;
`else
  assign wp = 1'b0;
`endif

  flash_prog_timer #(
    .WR_CYCLES (WR_CYCLES)
  ) u_timer (
    .SCLK           (SCLK),
    .RESETn_sclk    (RESETn_sclk),
    .load_sclk      (load),
    .word_done_sclk (word_done)
  );

  always_comb begin
    state_d   = state;
    wcnt_d    = wcnt;
    rdcnt_d   = rdcnt;
    abort_d   = abort_seen;
    busy_d    = busy_sclk;
    done_d    = 1'b0;
    resp_d    = resp_sclk;
    rdata_d   = rdata_sclk;
    cs_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = mem_addr_sclk;
    wdata_d   = mem_wdata_sclk;
    load      = 1'b0;
    abort_now = abort_seen | abort_sclk;
    is_rd     = (cmd_sclk == CMD_READ);
    is_pg     = is_prog_cmd(cmd_sclk) && !wp;

    unique case (state)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (cmd_valid_sclk) begin
          busy_d = 1'b1;
          unique case (1'b1)
            is_rd: begin
              state_d = ST_RD_ISSUE;
              cs_d    = 1'b1;
              addr_d  = addr_sclk;
            end
            is_pg: begin
              state_d = ST_PROG;
              cs_d    = 1'b1;
              we_d    = 1'b1;
              load    = 1'b1;
              abort_d = 1'b0;
              case (cmd_sclk)
                CMD_WRITE: begin
                  addr_d  = addr_sclk;
                  wdata_d = wdata_sclk;
                  wcnt_d  = N_ONE;
                end
                CMD_ROW_WRITE: begin
                  addr_d  = addr_sclk & ROW_MASK;
                  wdata_d = wdata_sclk;
                  wcnt_d  = N_ROW;
                end
                CMD_ERASE: begin
                  addr_d  = addr_sclk & ROW_MASK;
                  wdata_d = FILL;
                  wcnt_d  = N_ROW;
                end
                default: begin
                  addr_d  = '0;
                  wdata_d = FILL;
                  wcnt_d  = N_ALL;
                end
              endcase
            end
            default: begin
              // Unknown code or write-protected program.
              state_d = ST_DONE;
              done_d  = 1'b1;
              resp_d  = 1'b1;
            end
          endcase
        end
      end
      ST_RD_ISSUE: begin
        state_d = ST_RD_WAIT;
        rdcnt_d = RL_W'(READ_LAT - 1);
      end
      ST_RD_WAIT: begin
        if (rdcnt == '0) begin
          rdata_d = mem_rdata_sclk;
          state_d = ST_DONE;
          done_d  = 1'b1;
          resp_d  = 1'b0;
        end else begin
          rdcnt_d = rdcnt - 1'b1;
        end
      end
      ST_PROG, ST_PROG_WAIT: begin
        abort_d = abort_now;
        if (word_done) begin
          // An abort lets the current word finish, then stops.
          if (abort_now || (wcnt == N_ONE)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            resp_d  = abort_now;
          end else begin
            state_d = ST_PROG;
            cs_d    = 1'b1;
            we_d    = 1'b1;
            load    = 1'b1;
            addr_d  = mem_addr_sclk + 1'b1;
            wcnt_d  = wcnt - 1'b1;
          end
        end else begin
          state_d = ST_PROG_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SCLK or negedge RESETn_sclk) begin
    if (!RESETn_sclk) begin
      state          <= ST_IDLE;
      wcnt           <= '0;
      rdcnt          <= '0;
      abort_seen     <= 1'b0;
      busy_sclk      <= 1'b0;
      done_sclk      <= 1'b0;
      resp_sclk      <= 1'b0;
      rdata_sclk     <= '0;
      mem_cs_sclk    <= 1'b0;
      mem_we_sclk    <= 1'b0;
      mem_addr_sclk  <= '0;
      mem_wdata_sclk <= '0;
    end else begin
      state          <= state_d;
      wcnt           <= wcnt_d;
      rdcnt          <= rdcnt_d;
      abort_seen     <= abort_d;
      busy_sclk      <= busy_d;
      done_sclk      <= done_d;
      resp_sclk      <= resp_d;
      rdata_sclk     <= rdata_d;
      mem_cs_sclk    <= cs_d;
      mem_we_sclk    <= we_d;
      mem_addr_sclk  <= addr_d;
      mem_wdata_sclk <= wdata_d;
    end
  end

endmodule
